// File: rtl/cache_fill_arbiter.sv
// Arbitrates I-miss, D-miss and D write-through onto one pipelined memory port and streams block fills back.
// Optional: define FILL_CRITICAL_WORD_FIRST_EN to start fills at the missed word and wrap modulo BLK_WORDS.
module cache_fill_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BLK_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_miss,
    input  logic [ADDR_W-1:0]            i_miss_addr,
    input  logic                         d_miss,
    input  logic [ADDR_W-1:0]            d_miss_addr,
    input  logic                         d_wr,
    input  logic [ADDR_W-1:0]            d_wr_addr,
    input  logic [DATA_W-1:0]            d_wr_data,
    output logic                         mem_enable,
    output logic                         mem_wr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_data_valid,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic [DATA_W-1:0]            fill_data,
    output logic [$clog2(BLK_WORDS)-1:0] fill_word,
    output logic                         i_fill_we,
    output logic                         d_fill_we,
    output logic                         i_fill_done,
    output logic                         d_fill_done,
    output logic                         d_wr_ack,
    output logic                         arb_busy
);
    localparam int WW = $clog2(BLK_WORDS);
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * BLK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, STORE, FILL} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              req_d;
    logic [WW-1:0]     start_q, issue_cnt, beat_cnt;
    logic              issue_done;
    logic [ADDR_W-1:0] miss_addr;
    logic [WW-1:0]     start_sel, issue_word, beat_word;
    logic              last_beat;

    // D side wins a same-cycle tie with I: it is older in program order.
    assign miss_addr  = d_miss ? d_miss_addr : i_miss_addr;
`ifdef FILL_CRITICAL_WORD_FIRST_EN
    assign start_sel  = miss_addr[WW:1];
`else
    assign start_sel  = '0;
`endif
    assign issue_word = start_q + issue_cnt;
    assign beat_word  = start_q + beat_cnt;
    assign last_beat  = (beat_cnt == '1);
    assign arb_busy   = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_data   = '0;
        fill_word   = '0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        d_wr_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (d_wr)                  state_nxt = STORE;
                else if (d_miss || i_miss) state_nxt = FILL;
            end
            STORE: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
                d_wr_ack   = 1'b1;
                state_nxt  = IDLE;
            end
            FILL: begin
                // Issue and beat sides run independently; only the beat side ends the fill.
                if (!issue_done) begin
                    mem_enable = 1'b1;
                    mem_addr   = addr_q | ADDR_W'({issue_word, 1'b0});
                end
                fill_data = mem_rdata;
                fill_word = beat_word;
                if (mem_data_valid) begin
                    i_fill_we = !req_d;
                    d_fill_we = req_d;
                    if (last_beat) begin
                        i_fill_done = !req_d;
                        d_fill_done = req_d;
                        state_nxt   = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            req_d      <= 1'b0;
            start_q    <= '0;
            issue_cnt  <= '0;
            beat_cnt   <= '0;
            issue_done <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (d_wr) begin
                        addr_q  <= d_wr_addr;
                        wdata_q <= d_wr_data;
                    end else if (d_miss || i_miss) begin
                        req_d      <= d_miss;
                        addr_q     <= miss_addr & BLK_MASK;
                        start_q    <= start_sel;
                        issue_cnt  <= '0;
                        beat_cnt   <= '0;
                        issue_done <= 1'b0;
                    end
                end
                FILL: begin
                    if (!issue_done) begin
                        issue_cnt <= issue_cnt + 1'b1;
                        if (issue_cnt == '1) issue_done <= 1'b1;
                    end
                    if (mem_data_valid) beat_cnt <= beat_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
